// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The state encoding and requester IDs are used by the arbiter and any block that observes it.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_ECHO = 1'b1;

    localparam int unsigned DEFAULT_ACK_TIMEOUT = 16;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with occupancy count; head is meaningful only when not empty.
// A push into an empty FIFO becomes visible at the head one cycle later (no bypass).
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx engine between the CPU bridge and the echo path, round-robin,
// and runs the tx_start/tx_avai handshake with an acceptance timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req0_valid,
    input  logic [7:0]                  req0_data,
    output logic                        req0_ready,
    input  logic                        req1_valid,
    input  logic [7:0]                  req1_data,
    output logic                        req1_ready,
    input  logic                        tx_avai,
    output logic                        tx_start,
    output logic [7:0]                  tx_data,
    output logic                        busy,
    output logic                        last_grant,
    output logic [$clog2(FIFO_DEPTH):0] fifo0_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo1_count,
    output logic                        ack_err
);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    arb_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ptr_q, ptr_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          last_grant_q, last_grant_d;
    logic          ack_err_q, ack_err_d;

    logic [7:0]    head0, head1;
    logic          full0, full1, empty0, empty1;
    logic          pop0, pop1, grant, winner;

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo0 (
        .clk      (clk),
        .reset    (reset),
        .push     (req0_valid),
        .push_data(req0_data),
        .pop      (pop0),
        .head     (head0),
        .count    (fifo0_count),
        .full     (full0),
        .empty    (empty0)
    );

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo1 (
        .clk      (clk),
        .reset    (reset),
        .push     (req1_valid),
        .push_data(req1_data),
        .pop      (pop1),
        .head     (head1),
        .count    (fifo1_count),
        .full     (full1),
        .empty    (empty1)
    );

    always_comb begin
        // ptr only matters when both requesters are waiting.
        winner = (!empty0 && !empty1) ? ptr_q : (empty0 ? REQ_ECHO : REQ_CPU);
        grant  = (state_q == IDLE) && tx_avai && !(empty0 && empty1);
        pop0   = grant && (winner == REQ_CPU);
        pop1   = grant && (winner == REQ_ECHO);

        state_d      = state_q;
        timer_d      = timer_q;
        ptr_d        = ptr_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        last_grant_d = last_grant_q;
        ack_err_d    = ack_err_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    tx_data_d    = (winner == REQ_ECHO) ? head1 : head0;
                    tx_start_d   = 1'b1;
                    last_grant_d = winner;
                    ptr_d        = ~winner;
                    timer_d      = '0;
                    state_d      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!tx_avai) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    // Engine never took the byte: drop it and flag, no retry.
                    ack_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (tx_avai) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            ptr_q        <= REQ_CPU;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            last_grant_q <= REQ_CPU;
            ack_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ptr_q        <= ptr_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            last_grant_q <= last_grant_d;
            ack_err_q    <= ack_err_d;
        end
    end

    assign req0_ready = ~full0;
    assign req1_ready = ~full1;
    assign busy       = (state_q != IDLE);
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign last_grant = last_grant_q;
    assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic checked against
// a queue-based model of the round-robin grant order.
module tb_uart_tx_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [7:0]    req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          tx_avai;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          busy, last_grant, ack_err;
    logic [CW-1:0] fifo0_count, fifo1_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx_avai    (tx_avai),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .busy       (busy),
        .last_grant (last_grant),
        .fifo0_count(fifo0_count),
        .fifo1_count(fifo1_count),
        .ack_err    (ack_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tx_avai = 1'b1;
        do_reset();
        total++;
        if ({tx_start, busy, last_grant, ack_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b, want 0000", {tx_start, busy, last_grant, ack_err});
        end
        total++;
        if (tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: got %h, want 00", tx_data);
        end
        total++;
        if ({fifo0_count, fifo1_count, req0_ready, req1_ready} !== {CW'(0), CW'(0), 2'b11}) begin
            bad++;
            $display("FAIL reset_fifo: got c0=%0d c1=%0d rdy=%b%b, want 0 0 11",
                     fifo0_count, fifo1_count, req0_ready, req1_ready);
        end
    endtask

    task automatic test_single_byte();
        do_reset();
        tx_avai    = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 8'h41;
        tick();
        req0_valid = 1'b0;
        total++;
        if (tx_start !== 1'b0 || fifo0_count !== CW'(1)) begin
            bad++;
            $display("FAIL sb_no_bypass: got start=%b c0=%0d, want 0 1", tx_start, fifo0_count);
        end
        tick();
        total++;
        if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
            bad++;
            $display("FAIL sb_start: got start=%b data=%h, want 1 41", tx_start, tx_data);
        end
        total++;
        if (last_grant !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL sb_grant: got lg=%b busy=%b, want 0 1", last_grant, busy);
        end
        tx_avai = 1'b0;
        repeat (10) tick();
        total++;
        if (busy !== 1'b1 || tx_start !== 1'b0) begin
            bad++;
            $display("FAIL sb_frame: got busy=%b start=%b, want 1 0", busy, tx_start);
        end
        tx_avai = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL sb_busy_fall: got %b, want 0", busy);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [4];
        logic       exp_g [4];
        bit         seen;
        exp_d = '{8'h10, 8'h20, 8'h11, 8'h21};
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        tx_avai    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'h10;
        req1_data  = 8'h20;
        tick();
        req0_data = 8'h11;
        req1_data = 8'h21;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++;
        if (fifo0_count !== CW'(2) || fifo1_count !== CW'(2)) begin
            bad++;
            $display("FAIL rr_preload: got %0d %0d, want 2 2", fifo0_count, fifo1_count);
        end
        for (int k = 0; k < 4; k++) begin
            tx_avai = 1'b1;
            wait_start(20, seen);
            total++;
            if (!seen || tx_data !== exp_d[k] || last_grant !== exp_g[k]) begin
                bad++;
                $display("FAIL rr_order[%0d]: got seen=%b data=%h lg=%b, want 1 %h %b",
                         k, seen, tx_data, last_grant, exp_d[k], exp_g[k]);
            end
            tx_avai = 1'b0;
            repeat (3) tick();
        end
        tx_avai = 1'b1;
        tick();
    endtask

    task automatic test_full();
        do_reset();
        tx_avai    = 1'b0;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req1_data = 8'hA0 + 8'(k);
            tick();
        end
        total++;
        if (req1_ready !== 1'b0 || fifo1_count !== CW'(4)) begin
            bad++;
            $display("FAIL full_after4: got rdy=%b c1=%0d, want 0 4", req1_ready, fifo1_count);
        end
        req1_data = 8'hA4;
        repeat (3) tick();
        total++;
        if (req1_ready !== 1'b0 || fifo1_count !== CW'(4)) begin
            bad++;
            $display("FAIL full_hold: got rdy=%b c1=%0d, want 0 4", req1_ready, fifo1_count);
        end
        tx_avai = 1'b1;
        tick();
        total++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA0 || fifo1_count !== CW'(3)) begin
            bad++;
            $display("FAIL full_pop: got start=%b data=%h c1=%0d, want 1 a0 3",
                     tx_start, tx_data, fifo1_count);
        end
        tick();
        req1_valid = 1'b0;
        total++;
        if (fifo1_count !== CW'(4)) begin
            bad++;
            $display("FAIL full_5th_accept: got %0d, want 4", fifo1_count);
        end
        tx_avai = 1'b0;
        tick();
    endtask

    task automatic test_simul_push_pop();
        bit seen;
        do_reset();
        tx_avai    = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h33;
        tick();
        req0_data = 8'h55;
        tx_avai   = 1'b1;
        tick();
        req0_valid = 1'b0;
        total++;
        if (tx_start !== 1'b1 || tx_data !== 8'h33 || fifo0_count !== CW'(1)) begin
            bad++;
            $display("FAIL pp_same_cycle: got start=%b data=%h c0=%0d, want 1 33 1",
                     tx_start, tx_data, fifo0_count);
        end
        tx_avai = 1'b0;
        repeat (2) tick();
        tx_avai = 1'b1;
        wait_start(10, seen);
        total++;
        if (!seen || tx_data !== 8'h55 || fifo0_count !== CW'(0)) begin
            bad++;
            $display("FAIL pp_next_grant: got seen=%b data=%h c0=%0d, want 1 55 0",
                     seen, tx_data, fifo0_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        tx_avai    = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h61;
        tick();
        req0_data = 8'h62;
        tick();
        req0_valid = 1'b0;
        tx_avai    = 1'b1;
        tick();
        total++;
        if (tx_start !== 1'b1 || tx_data !== 8'h61) begin
            bad++;
            $display("FAIL to_grant: got start=%b data=%h, want 1 61", tx_start, tx_data);
        end
        repeat (TMO - 1) tick();
        total++;
        if (ack_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL to_early: got err=%b busy=%b, want 0 1", ack_err, busy);
        end
        tick();
        total++;
        if (ack_err !== 1'b1 || busy !== 1'b0 || tx_start !== 1'b0) begin
            bad++;
            $display("FAIL to_expire: got err=%b busy=%b start=%b, want 1 0 0",
                     ack_err, busy, tx_start);
        end
        tick();
        total++;
        if (tx_start !== 1'b1 || tx_data !== 8'h62) begin
            bad++;
            $display("FAIL to_next_grant: got start=%b data=%h, want 1 62", tx_start, tx_data);
        end
        tx_avai = 1'b0;
        repeat (3) tick();
        tx_avai = 1'b1;
        repeat (2) tick();
        total++;
        if (ack_err !== 1'b1) begin
            bad++;
            $display("FAIL to_sticky: got %b, want 1", ack_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        do_reset();
        tx_avai    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'h71;
        req1_data  = 8'h81;
        tick();
        req0_data = 8'h72;
        req1_data = 8'h82;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tx_avai    = 1'b1;
        tick();
        tx_avai = 1'b0;
        tick();
        total++;
        if (busy !== 1'b1 || fifo0_count !== CW'(1) || fifo1_count !== CW'(2)) begin
            bad++;
            $display("FAIL rm_pre: got busy=%b c0=%0d c1=%0d, want 1 1 2",
                     busy, fifo0_count, fifo1_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (fifo0_count !== CW'(0) || fifo1_count !== CW'(0) || tx_data !== 8'h00) begin
            bad++;
            $display("FAIL rm_cleared: got c0=%0d c1=%0d data=%h, want 0 0 00",
                     fifo0_count, fifo1_count, tx_data);
        end
        total++;
        if ({busy, tx_start, last_grant, req0_ready, req1_ready} !== 5'b00011) begin
            bad++;
            $display("FAIL rm_flags: got %b, want 00011",
                     {busy, tx_start, last_grant, req0_ready, req1_ready});
        end
        tx_avai = 1'b1;
        seen    = 1'b0;
        repeat (8) begin
            tick();
            if (tx_start === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rm_quiet: got start seen=1, want 0");
        end
        req1_valid = 1'b1;
        req1_data  = 8'h99;
        tick();
        req1_valid = 1'b0;
        tick();
        total++;
        if (tx_start !== 1'b1 || tx_data !== 8'h99 || last_grant !== 1'b1) begin
            bad++;
            $display("FAIL rm_new_push: got start=%b data=%h lg=%b, want 1 99 1",
                     tx_start, tx_data, last_grant);
        end
    endtask

    task automatic test_random();
        logic [7:0] q0 [$];
        logic [7:0] q1 [$];
        logic [7:0] d0, d1, exp_b;
        bit         v0, v1, acc0, acc1, win, mptr, prev_start, feeding;
        int         e_wait, e_low, grants, accepted;
        v0 = 0; v1 = 0; mptr = 0; prev_start = 0;
        d0 = 8'h00; d1 = 8'h00;
        e_wait = -1; e_low = 0; grants = 0; accepted = 0;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            feeding = (cyc < 600);
            if (!v0 && feeding && $urandom_range(0, 2) == 0) begin
                v0 = 1'b1;
                d0 = 8'($urandom);
            end
            if (!v1 && feeding && $urandom_range(0, 2) == 0) begin
                v1 = 1'b1;
                d1 = 8'($urandom);
            end
            req0_valid = v0;
            req0_data  = d0;
            req1_valid = v1;
            req1_data  = d1;
            // Engine model: accept after 0..3 cycles, stay busy 1..6 cycles.
            if (e_wait > 0) begin
                tx_avai = 1'b1;
                e_wait--;
            end else if (e_wait == 0) begin
                tx_avai = 1'b0;
                e_wait  = -1;
                e_low   = $urandom_range(0, 5);
            end else if (e_low > 0) begin
                tx_avai = 1'b0;
                e_low--;
            end else begin
                tx_avai = 1'b1;
            end
            total++;
            if (req0_ready !== (q0.size() != int'(DEPTH))) begin
                bad++;
                $display("FAIL rnd_ready0 @%0d: got %b, model size %0d", cyc, req0_ready, q0.size());
            end
            total++;
            if (req1_ready !== (q1.size() != int'(DEPTH))) begin
                bad++;
                $display("FAIL rnd_ready1 @%0d: got %b, model size %0d", cyc, req1_ready, q1.size());
            end
            acc0 = v0 && (q0.size() != int'(DEPTH));
            acc1 = v1 && (q1.size() != int'(DEPTH));
            tick();
            if (tx_start === 1'b1) begin
                total++;
                if (prev_start) begin
                    bad++;
                    $display("FAIL rnd_back_to_back @%0d: got two starts, want one", cyc);
                end
                total++;
                if (q0.size() == 0 && q1.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_spurious @%0d: got start, want none (queues empty)", cyc);
                end else begin
                    win   = (q0.size() != 0 && q1.size() != 0) ? mptr : (q1.size() != 0);
                    exp_b = win ? q1.pop_front() : q0.pop_front();
                    mptr  = ~win;
                    if (tx_data !== exp_b || last_grant !== win) begin
                        bad++;
                        $display("FAIL rnd_grant @%0d: got data=%h lg=%b, want %h %b",
                                 cyc, tx_data, last_grant, exp_b, win);
                    end
                end
                grants++;
                e_wait = $urandom_range(0, 3);
            end
            prev_start = tx_start;
            if (acc0) begin
                q0.push_back(d0);
                v0 = 1'b0;
                accepted++;
            end
            if (acc1) begin
                q1.push_back(d1);
                v1 = 1'b0;
                accepted++;
            end
            total++;
            if (fifo0_count !== CW'(q0.size()) || fifo1_count !== CW'(q1.size())) begin
                bad++;
                $display("FAIL rnd_counts @%0d: got %0d %0d, want %0d %0d",
                         cyc, fifo0_count, fifo1_count, q0.size(), q1.size());
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++;
        if (grants < 20 || grants != accepted || ack_err !== 1'b0) begin
            bad++;
            $display("FAIL rnd_totals: got grants=%0d err=%b, want accepted=%0d (>=20) err=0",
                     grants, ack_err, accepted);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        tx_avai = 1'b1;
        test_reset();
        test_single_byte();
        test_round_robin();
        test_full();
        test_simul_push_pop();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
